adder_err_eval: RTL

Sequential exhaustive error evaluator for a combinational IN_W-bit adder netlist (8-input/5-output adder for IN_W=4). Drives every operand pair onto the adder's primary inputs and reads its primary outputs. Compares each result against the exact sum and accumulates error statistics: mismatch count, maximum absolute error, summed absolute error and first failing vector. Sits in the evaluation harness around exact or approximate adder netlists.

---
 rtl/adder_err_eval_if.sv | 47 ++++
 rtl/adder_err_eval.sv | 134 +++++++++++++
 2 files changed

// File: rtl/adder_err_eval_if.sv
// adder_err_eval bus: sweep control, adder stimulus/response and statistics.
// The slave side is the evaluator; the master side is the harness around it.
interface adder_err_eval_if #(
  parameter int IN_W = 4
);
  localparam int OUT_W = IN_W + 1;
  localparam int VW    = 2 * IN_W;
  localparam int CW    = 2 * IN_W + 1;
  localparam int SW    = 2 * IN_W + OUT_W;

  logic             start;
  logic [VW-1:0]    stim;
  logic [OUT_W-1:0] dut_sum;
  logic             busy;
  logic             done;
  logic [CW-1:0]    err_count;
  logic [OUT_W-1:0] max_abs_err;
  logic [SW-1:0]    sum_abs_err;
  logic             first_err_vld;
  logic [VW-1:0]    first_err_vec;

  modport slave (
    input  start,
    input  dut_sum,
    output stim,
    output busy,
    output done,
    output err_count,
    output max_abs_err,
    output sum_abs_err,
    output first_err_vld,
    output first_err_vec
  );

  modport master (
    output start,
    output dut_sum,
    input  stim,
    input  busy,
    input  done,
    input  err_count,
    input  max_abs_err,
    input  sum_abs_err,
    input  first_err_vld,
    input  first_err_vec
  );
endinterface

// File: rtl/adder_err_eval.sv
// Exhaustive error evaluator for an IN_W-bit adder netlist.
// Two-stage pipe: capture exact/observed sum, then accumulate error stats.
module adder_err_eval #(
  parameter int IN_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  adder_err_eval_if.slave    bus
);
  localparam int OUT_W = IN_W + 1;
  localparam int VW    = 2 * IN_W;
  localparam int CW    = 2 * IN_W + 1;
  localparam int SW    = 2 * IN_W + OUT_W;
  localparam logic [VW-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  logic [VW-1:0]    stim_q;
  logic             s1_vld;
  logic [VW-1:0]    s1_vec;
  logic [OUT_W-1:0] exact_q;
  logic [OUT_W-1:0] obs_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    err_q;
  logic [OUT_W-1:0] max_q;
  logic [SW-1:0]    sum_q;
  logic             fvld_q;
  logic [VW-1:0]    fvec_q;

  logic [IN_W-1:0]  op_a;
  logic [IN_W-1:0]  op_b;
  logic [OUT_W-1:0] exact_d;
  logic [OUT_W-1:0] abs_d;

  assign op_a    = stim_q[IN_W-1:0];
  assign op_b    = stim_q[VW-1:IN_W];
  assign exact_d = OUT_W'(op_a) + OUT_W'(op_b);

  // Magnitude of the stage-1 error; both operands are OUT_W so no overflow.
  always_comb begin
    abs_d = '0;
    if (obs_q >= exact_q) abs_d = obs_q - exact_q;
    else                  abs_d = exact_q - obs_q;
  end

  // Sweep FSM, stimulus counter, capture stage and statistics accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      stim_q  <= '0;
      s1_vld  <= 1'b0;
      s1_vec  <= '0;
      exact_q <= '0;
      obs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      max_q   <= '0;
      sum_q   <= '0;
      fvld_q  <= 1'b0;
      fvec_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          s1_vld <= 1'b0;
          done_q <= 1'b0;
          stim_q <= '0;
          if (bus.start) begin
            state  <= SWEEP;
            busy_q <= 1'b1;
            err_q  <= '0;
            max_q  <= '0;
            sum_q  <= '0;
            fvld_q <= 1'b0;
            fvec_q <= '0;
          end
        end
        SWEEP: begin
          exact_q <= exact_d;
          obs_q   <= bus.dut_sum;
          s1_vld  <= 1'b1;
          s1_vec  <= stim_q;
          stim_q  <= stim_q + VW'(1);
          if (stim_q == LAST) begin
            stim_q <= '0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          s1_vld <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (s1_vld) begin
        sum_q <= sum_q + SW'(abs_d);
        if (abs_d > max_q) max_q <= abs_d;
        if (abs_d != '0) begin
          err_q <= err_q + CW'(1);
          if (!fvld_q) begin
            fvld_q <= 1'b1;
            fvec_q <= s1_vec;
          end
        end
      end
    end
  end

  assign bus.stim          = stim_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err_count     = err_q;
  assign bus.max_abs_err   = max_q;
  assign bus.sum_abs_err   = sum_q;
  assign bus.first_err_vld = fvld_q;
  assign bus.first_err_vec = fvec_q;

endmodule
